uart_voice_allocator: RTL

//  Note-command parser and voice allocator between the UART receiver and the tone generators.

---
 rtl/uart_voice_allocator.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_voice_allocator.sv
// uart_voice_allocator
//   Parses the byte stream from the UART receiver as 2-byte note-on/note-off
//   commands (with running status) and shares C_VOICES tone-generator voices
//   among the incoming notes. Free voices are allocated lowest-index first,
//   note-off releases the matching voice, and when every voice is busy one is
//   stolen round-robin.
//
// Ports
//   i_Clock, i_Rst_L          clock, asynchronous active-low reset
//   i_RX_DV, i_RX_Byte        byte-valid pulse and byte from the UART receiver
//   i_Panic                   (VOICE_ALLOC_PANIC_EN only) all-notes-off pulse
//   o_Voice_En                per-voice active flag
//   o_Voice_Note              voice v note at [v*C_NOTE_WIDTH +: C_NOTE_WIDTH]
//   o_Cmd_Err                 pulse: bad status, orphan data byte, or timeout
//   o_Steal                   pulse: a busy voice was reassigned
//   o_Overrun                 pulse: byte dropped, holding register full
//   o_Busy                    high while scanning/applying an allocation
//
// Build option
//   VOICE_ALLOC_PANIC_EN      adds i_Panic and the 0xBn,0x7B all-notes-off
//                             command; otherwise 0xBn is a bad status byte.
module uart_voice_allocator #(
    parameter int C_VOICES     = 4,
    parameter int C_NOTE_WIDTH = 7,
    parameter int C_TIMEOUT    = 100_000
) (
    input  logic                             i_Clock,
    input  logic                             i_Rst_L,
    input  logic                             i_RX_DV,
    input  logic [7:0]                       i_RX_Byte,
`ifdef VOICE_ALLOC_PANIC_EN
    input  logic                             i_Panic,
`endif
    output logic [C_VOICES-1:0]              o_Voice_En,
    output logic [C_VOICES*C_NOTE_WIDTH-1:0] o_Voice_Note,
    output logic                             o_Cmd_Err,
    output logic                             o_Steal,
    output logic                             o_Overrun,
    output logic                             o_Busy
);
    localparam int VW = (C_VOICES > 1) ? $clog2(C_VOICES) : 1;
    localparam int TW = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT) : 1;
    localparam logic [VW-1:0] LAST_V = VW'(C_VOICES - 1);
    localparam logic [TW-1:0] TMAX   = TW'(C_TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_NOTE, S_SCAN, S_APPLY} state_t;
    typedef enum logic [1:0] {CMD_OFF, CMD_ON, CMD_CC} cmd_t;

    state_t                               state_q, state_d;
    cmd_t                                 rs_q, rs_d;
    logic                                 rs_vld_q, rs_vld_d;
    logic                                 hold_vld_q, hold_vld_d;
    logic [7:0]                           hold_q, hold_d;
    logic [TW-1:0]                        timer_q, timer_d;
    logic                                 pend_on_q, pend_on_d;
    logic [C_NOTE_WIDTH-1:0]              pend_note_q, pend_note_d;
    logic [VW-1:0]                        idx_q, idx_d;
    logic                                 match_q, match_d, free_q, free_d;
    logic [VW-1:0]                        match_idx_q, match_idx_d;
    logic [VW-1:0]                        free_idx_q, free_idx_d;
    logic [VW-1:0]                        steal_q, steal_d;
    logic [C_VOICES-1:0]                  en_q, en_d;
    logic [C_VOICES-1:0][C_NOTE_WIDTH-1:0] vnote_q, vnote_d;
    logic                                 err_q, err_d, stl_q, stl_d, ovr_q, ovr_d;

    logic is_on, is_off, is_cc, is_data, ext_panic;
    assign is_on   = (hold_q[7:4] == 4'h9);
    assign is_off  = (hold_q[7:4] == 4'h8);
    assign is_data = ~hold_q[7];
`ifdef VOICE_ALLOC_PANIC_EN
    assign is_cc     = (hold_q[7:4] == 4'hB);
    assign ext_panic = i_Panic;
`else
    assign is_cc     = 1'b0;
    assign ext_panic = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        rs_d        = rs_q;
        rs_vld_d    = rs_vld_q;
        hold_vld_d  = hold_vld_q;
        hold_d      = hold_q;
        timer_d     = timer_q;
        pend_on_d   = pend_on_q;
        pend_note_d = pend_note_q;
        idx_d       = idx_q;
        match_d     = match_q;
        match_idx_d = match_idx_q;
        free_d      = free_q;
        free_idx_d  = free_idx_q;
        steal_d     = steal_q;
        en_d        = en_q;
        vnote_d     = vnote_q;
        err_d       = 1'b0;
        stl_d       = 1'b0;
        ovr_d       = 1'b0;

        // Holding register is consumed here only in S_IDLE/S_WAIT_NOTE;
        // panic_cmd collects the in-band all-notes-off request.
        begin : fsm
            logic consume, panic_cmd;
            consume   = 1'b0;
            panic_cmd = 1'b0;
            case (state_q)
                S_IDLE, S_WAIT_NOTE: begin
                    if (state_q == S_WAIT_NOTE) timer_d = timer_q + TW'(1);
                    if (hold_vld_q) begin
                        consume = 1'b1;
                        if (is_on || is_off || is_cc) begin
                            rs_d     = is_on ? CMD_ON : (is_off ? CMD_OFF : CMD_CC);
                            rs_vld_d = 1'b1;
                            timer_d  = '0;        // restart even when already waiting
                            state_d  = S_WAIT_NOTE;
                        end else if (is_data) begin
                            if (!rs_vld_q) begin
                                err_d   = 1'b1;
                                state_d = S_IDLE;
                            end else if (rs_q == CMD_CC) begin
                                panic_cmd = (hold_q == 8'h7B);
                                state_d   = S_IDLE;  // other controllers ignored
                            end else begin
                                pend_on_d   = (rs_q == CMD_ON);
                                pend_note_d = hold_q[C_NOTE_WIDTH-1:0];
                                idx_d       = '0;
                                match_d     = 1'b0;
                                free_d      = 1'b0;
                                state_d     = S_SCAN;
                            end
                        end else begin
                            rs_vld_d = 1'b0;
                            err_d    = 1'b1;
                            state_d  = S_IDLE;
                        end
                    end else if (state_q == S_WAIT_NOTE && timer_q == TMAX) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_SCAN: begin
                    if (en_q[idx_q] && vnote_q[idx_q] == pend_note_q && !match_q) begin
                        match_d     = 1'b1;
                        match_idx_d = idx_q;
                    end
                    if (!en_q[idx_q] && !free_q) begin
                        free_d     = 1'b1;
                        free_idx_d = idx_q;
                    end
                    if (idx_q == LAST_V) state_d = S_APPLY;
                    else                 idx_d   = idx_q + VW'(1);
                end
                S_APPLY: begin
                    state_d = S_IDLE;
                    if (pend_on_q) begin
                        if (!match_q && free_q) begin
                            en_d[free_idx_q]    = 1'b1;
                            vnote_d[free_idx_q] = pend_note_q;
                        end else if (!match_q) begin
                            en_d[steal_q]    = 1'b1;
                            vnote_d[steal_q] = pend_note_q;
                            stl_d            = 1'b1;
                            steal_d          = (steal_q == LAST_V) ? '0 : steal_q + VW'(1);
                        end
                    end else if (match_q) begin
                        en_d[match_idx_q] = 1'b0;   // note value kept for inspection
                    end
                end
                default: state_d = S_IDLE;
            endcase

            if (state_d != state_q) timer_d = '0;

            // Holding register: a byte arriving while the old one is consumed
            // in the same cycle is accepted without overrun.
            hold_vld_d = hold_vld_q & ~consume;
            if (i_RX_DV) begin
                if (hold_vld_d) begin
                    ovr_d = 1'b1;
                end else begin
                    hold_vld_d = 1'b1;
                    hold_d     = i_RX_Byte;
                end
            end

            if (panic_cmd || ext_panic) begin
                en_d       = '0;
                rs_vld_d   = 1'b0;
                hold_vld_d = 1'b0;
                steal_d    = '0;
                state_d    = S_IDLE;
                timer_d    = '0;
                stl_d      = 1'b0;
                ovr_d      = 1'b0;
            end
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q     <= S_IDLE;
            rs_q        <= CMD_OFF;
            rs_vld_q    <= 1'b0;
            hold_vld_q  <= 1'b0;
            hold_q      <= '0;
            timer_q     <= '0;
            pend_on_q   <= 1'b0;
            pend_note_q <= '0;
            idx_q       <= '0;
            match_q     <= 1'b0;
            match_idx_q <= '0;
            free_q      <= 1'b0;
            free_idx_q  <= '0;
            steal_q     <= '0;
            en_q        <= '0;
            vnote_q     <= '0;
            err_q       <= 1'b0;
            stl_q       <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rs_q        <= rs_d;
            rs_vld_q    <= rs_vld_d;
            hold_vld_q  <= hold_vld_d;
            hold_q      <= hold_d;
            timer_q     <= timer_d;
            pend_on_q   <= pend_on_d;
            pend_note_q <= pend_note_d;
            idx_q       <= idx_d;
            match_q     <= match_d;
            match_idx_q <= match_idx_d;
            free_q      <= free_d;
            free_idx_q  <= free_idx_d;
            steal_q     <= steal_d;
            en_q        <= en_d;
            vnote_q     <= vnote_d;
            err_q       <= err_d;
            stl_q       <= stl_d;
            ovr_q       <= ovr_d;
        end
    end

    assign o_Voice_En   = en_q;
    assign o_Voice_Note = vnote_q;
    assign o_Cmd_Err    = err_q;
    assign o_Steal      = stl_q;
    assign o_Overrun    = ovr_q;
    assign o_Busy       = (state_q == S_SCAN) || (state_q == S_APPLY);
endmodule
